// File: rtl/dii_packet_fifo_if.sv
// dii_packet_fifo_if: DII flit channel carrying data, first/last markers and a valid/ready handshake
interface dii_channel #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             first;
  logic             last;
  logic             valid;
  logic             ready;
  modport master (output data, first, last, valid, input ready);
  modport slave (input data, first, last, valid, output ready);
endinterface

// File: rtl/dii_packet_fifo.sv
// dii_packet_fifo: circular-buffer DII flit FIFO with optional store-and-forward and cut-through fallback
module dii_packet_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter bit FULLPACKET = 1'b0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  dii_channel.slave         in,
  dii_channel.master        out,
  output logic [AW:0]       level,
  output logic [AW:0]       packet_count
);
  logic [WIDTH+1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic [AW:0]      r_pkt;
  logic             r_drain;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH+1:0] w_head;

  assign w_empty      = r_wp == r_rp;
  assign w_full       = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
  assign w_head       = r_mem[r_rp[AW-1:0]];
  assign in.ready     = !w_full;
  // a stored last flit, a full buffer (cut-through) or an already released packet head lets output run
  assign out.valid    = !w_empty && (!FULLPACKET || r_pkt != '0 || w_full || r_drain);
  assign {out.data, out.first, out.last} = w_head;
  assign w_push       = in.valid && !w_full;
  assign w_pop        = out.valid && out.ready;
  assign level        = r_wp - r_rp;
  assign packet_count = r_pkt;

  // flit storage, deliberately left uncleared by reset
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {in.data, in.first, in.last};

  // pointers with wrap bit, complete-packet counter and mid-packet draining flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_pkt   <= '0;
      r_drain <= 1'b0;
    end else begin
      r_wp  <= r_wp + (AW+1)'(w_push);
      r_rp  <= r_rp + (AW+1)'(w_pop);
      r_pkt <= r_pkt + (AW+1)'(w_push && in.last) - (AW+1)'(w_pop && out.last);
      if (w_pop) r_drain <= !out.last;
    end
endmodule

// File: tb/tb_dii_packet_fifo.sv
// tb_dii_packet_fifo: randomized and directed checks of both FIFO modes against a queue model
module tb_dii_packet_fifo;
  localparam int W = 16;
  localparam int D = 8;
  localparam int AW = $clog2(D);
  typedef logic [W+1:0] flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv = 1'b0;
  logic [W-1:0] id = '0;
  logic ifst = 1'b0;
  logic ilst = 1'b0;
  logic ordy = 1'b0;

  logic          ir [2];
  logic          ov [2];
  logic [W-1:0]  od [2];
  logic          of [2];
  logic          ol [2];
  logic [AW:0]   lv [2];
  logic [AW:0]   pc [2];

  int checks = 0;
  int errors = 0;
  flit_t mq [2][$];
  bit mid [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    dii_channel #(.WIDTH(W)) ci ();
    dii_channel #(.WIDTH(W)) co ();
    assign ci.valid = iv;
    assign ci.data  = id;
    assign ci.first = ifst;
    assign ci.last  = ilst;
    assign co.ready = ordy;
    assign ir[g] = ci.ready;
    assign ov[g] = co.valid;
    assign od[g] = co.data;
    assign of[g] = co.first;
    assign ol[g] = co.last;
    dii_packet_fifo #(.WIDTH(W), .DEPTH(D), .FULLPACKET(1'(g))) dut (
      .clk(clk),
      .rst(rst),
      .in(ci),
      .out(co),
      .level(lv[g]),
      .packet_count(pc[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_valid(input int k);
    int n = mq[k].size();
    int pk = 0;
    foreach (mq[k][j]) pk += int'(mq[k][j][0]);
    return n > 0 && (k == 0 || pk > 0 || n == D || mid[k]);
  endfunction

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      int pk = 0;
      foreach (mq[k][j]) pk += int'(mq[k][j][0]);
      chk($sformatf("level%0d", k), 32'(lv[k]), mq[k].size());
      chk($sformatf("pkt%0d", k), 32'(pc[k]), pk);
      chk($sformatf("in_ready%0d", k), 32'(ir[k]), 32'(mq[k].size() < D));
      chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(exp_valid(k)));
      if (exp_valid(k)) chk($sformatf("head%0d", k), 32'({od[k], of[k], ol[k]}), 32'(mq[k][0]));
    end
  endtask

  task automatic cyc();
    bit psh [2];
    bit pp [2];
    compare();
    for (int k = 0; k < 2; k++) begin
      psh[k] = iv && mq[k].size() < D;
      pp[k] = exp_valid(k) && ordy;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (pp[k]) mid[k] = !mq[k].pop_front()[0];
      if (psh[k]) mq[k].push_back({id, ifst, ilst});
    end
    #1;
  endtask

  task automatic drv(input logic v, input logic [W-1:0] d, input logic f, input logic l, input logic r);
    iv = v;
    id = d;
    ifst = f;
    ilst = l;
    ordy = r;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mid[k] = 1'b0;
    end
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);
      cyc();
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    compare();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drv(1'b1, 16'h00aa, 1'b0, 1'b1, 1'b0);
    cyc();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc();
    cyc();
    for (int i = 1; i <= 8; i++) begin
      drv(1'b1, 16'(i), 1'b1, 1'b1, 1'b0);
      cyc();
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (9) cyc();
    for (int i = 0; i < 40; i++) begin
      drv(1'b1, 16'(i), 1'b1, 1'b1, 1'b1);
      cyc();
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 16'(16'h300 + i), i == 0, i == 2, 1'b1);
      cyc();
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (5) cyc();
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 16'(16'h400 + i), i == 0, i == 11, 1'b1);
      cyc();
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (14) cyc();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 16'(16'h500 + i), 1'b1, 1'b1, 1'b0);
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 16'(16'h600 + i), 1'b1, 1'b1, 1'b1);
      cyc();
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (10) cyc();
    for (int i = 0; i < 1500; i++) begin
      drv($urandom_range(3) != 0, 16'($urandom), 1'($urandom), $urandom_range(4) == 0, $urandom_range(2) != 0);
      cyc();
    end
    drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (12) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
